// File: rtl/snoop_loader.sv
// rtl/snoop_loader.sv - byte-stream command interpreter driving the discus snoop port
module snoop_loader #(
  parameter int READ_LAT = 2,
  parameter int TIMEOUT  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       cpu_reset,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  output logic       snoopp,
  input  logic [7:0] snoopq
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);

  typedef enum logic [3:0] {
    IDLE, W_ADDR, W_DATA, L_ADDR, L_CNT, L_DATA, R_ADDR, RD_WAIT, TX
  } state_t;

  state_t        state;
  logic [7:0]    addr;     // target address, auto-increments during block load
  logic [7:0]    rem;      // block-load bytes remaining minus one (255 = 256 bytes)
  logic [TW-1:0] tcnt;     // idle cycles since the last byte of a command
  logic [RW-1:0] rd_cnt;   // cycles spent waiting for snoopq

  // Command FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      rem       <= '0;
      tcnt      <= '0;
      rd_cnt    <= '0;
      cpu_reset <= 1'b1;
      snoopa    <= '0;
      snoopd    <= '0;
      snoopp    <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
    end else begin
      snoopp <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (rx_valid) begin
            case (rx_data)
              8'h48:   cpu_reset <= 1'b1;
              8'h47:   cpu_reset <= 1'b0;
              8'h57:   state <= W_ADDR;
              8'h4C:   state <= L_ADDR;
              8'h52:   state <= R_ADDR;
              default: ;
            endcase
          end
        end
        W_ADDR, W_DATA, L_ADDR, L_CNT, L_DATA, R_ADDR: begin
          if (rx_valid) begin
            tcnt <= '0;
            case (state)
              W_ADDR: begin
                addr  <= rx_data;
                state <= W_DATA;
              end
              W_DATA: begin
                snoopa <= addr;
                snoopd <= rx_data;
                snoopp <= 1'b1;
                state  <= IDLE;
              end
              L_ADDR: begin
                addr  <= rx_data;
                state <= L_CNT;
              end
              L_CNT: begin
                rem   <= rx_data - 8'd1;
                state <= L_DATA;
              end
              L_DATA: begin
                snoopa <= addr;
                snoopd <= rx_data;
                snoopp <= 1'b1;
                addr   <= addr + 8'd1;
                if (rem == 8'd0) state <= IDLE;
                else             rem   <= rem - 8'd1;
              end
              R_ADDR: begin
                snoopa <= rx_data;
                rd_cnt <= '0;
                busy   <= 1'b1;
                state  <= RD_WAIT;
              end
              default: state <= IDLE;
            endcase
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            tcnt  <= '0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RD_WAIT: begin
          if (rd_cnt == RW'(READ_LAT)) begin
            tx_data  <= snoopq;
            tx_valid <= 1'b1;
            state    <= TX;
          end else begin
            rd_cnt <= rd_cnt + RW'(1);
          end
        end
        TX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_loader.sv
// tb/tb_snoop_loader.sv - randomized self-checking bench for snoop_loader
module tb_snoop_loader;
  localparam int RL = 2;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       cpu_reset;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic       snoopp;
  logic [7:0] snoopq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  dmem [256];
  logic [7:0]  dpipe [RL];
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  int          obs_t [$];
  logic        exp_cpu;

  snoop_loader #(.READ_LAT(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .cpu_reset(cpu_reset), .snoopa(snoopa), .snoopd(snoopd), .snoopp(snoopp),
    .snoopq(snoopq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // discus snoop port model: write memory plus READ_LAT-deep read pipeline
  always @(posedge clk) begin
    if (snoopp === 1'b1) dmem[snoopa] <= snoopd;
    dpipe[0] <= dmem[snoopa];
    for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
  end
  assign snoopq = dpipe[RL-1];

  // record every observed write pulse
  always @(negedge clk) begin
    if (snoopp === 1'b1) begin
      obs_q.push_back({snoopa, snoopd});
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    ref_mem[a] = d;
  endtask

  task automatic compare_writes(input string tag, input bit consec);
    int n;
    idle(2);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_wr"}, {16'h0, obs_q[i]}, {16'h0, exp_q[i]});
      if (consec && i > 0) check({tag, "_b2b"}, obs_t[i] - obs_t[i-1], 1);
    end
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
  endtask

  task automatic cmd_w(input logic [7:0] a, input logic [7:0] d, input int gap);
    send(8'h57); idle(gap);
    send(a);     idle(gap);
    send(d);
    exp_wr(a, d);
  endtask

  task automatic cmd_l(input logic [7:0] a, input logic [7:0] cnt, input int gap);
    int n;
    logic [7:0] d;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    send(8'h4C); idle(gap);
    send(a);     idle(gap);
    send(cnt);   idle(gap);
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      send(d);
      exp_wr(a + 8'(i), d);
      if (i < n - 1) idle(gap);
    end
  endtask

  task automatic cmd_r(input logic [7:0] a, input int hold, input int gap);
    int lat;
    send(8'h52); idle(gap);
    send(a);
    check("rd_busy_wait", busy, 1);
    lat = 0;
    while (tx_valid !== 1'b1 && lat < 20) begin idle(1); lat++; end
    check("rd_latency", lat, RL + 1);
    check("rd_busy_tx", busy, 1);
    check("rd_data", tx_data, ref_mem[a]);
    idle(hold);
    check("rd_held", tx_valid, 1);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    check("rd_done_valid", tx_valid, 0);
    check("rd_done_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] b;
    int op;
    int gap;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      dmem[i] = b;
      ref_mem[i] = b;
    end

    idle(3);
    reset = 1'b0;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_snoopp", snoopp, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_snoopa", snoopa, 0);
    check("rst_tx_data", tx_data, 0);

    send(8'h47); check("g_cpu_reset", cpu_reset, 0);
    send(8'h48); check("h_cpu_reset", cpu_reset, 1);

    cmd_w(8'h03, 8'hE0, 0);
    compare_writes("w_single", 0);
    cmd_r(8'h03, 0, 0);

    cmd_l(8'hFE, 8'h03, 0);
    compare_writes("l_wrap", 1);

    cmd_l(8'h00, 8'h00, 0);
    compare_writes("l_256", 1);
    send(8'h47); check("l_256_idle", cpu_reset, 0);
    send(8'h48); check("l_256_idle_h", cpu_reset, 1);

    send(8'h57); send(8'h10); idle(TO); send(8'h55);
    compare_writes("timeout_abort", 0);
    send(8'h57); send(8'h10); idle(TO - 1); send(8'h55);
    exp_wr(8'h10, 8'h55);
    compare_writes("timeout_edge", 0);

    send(8'h52); send(8'h05);
    idle(RL + 1);
    check("tx_valid_rise", tx_valid, 1);
    idle(4); send(8'h47); idle(4);
    check("tx_hold_valid", tx_valid, 1);
    check("tx_hold_busy", busy, 1);
    check("tx_hold_data", tx_data, ref_mem[8'h05]);
    check("tx_g_discarded", cpu_reset, 1);
    tx_ready = 1'b1; idle(1); tx_ready = 1'b0;
    check("tx_xfer_valid", tx_valid, 0);
    check("tx_xfer_busy", busy, 0);
    idle(2);
    check("tx_single_xfer", tx_valid, 0);

    exp_cpu = 1'b1;
    for (int k = 0; k < 40; k++) begin
      op  = $urandom_range(0, 5);
      gap = $urandom_range(0, 3);
      case (op)
        0: begin cmd_w(8'($urandom), 8'($urandom), gap); compare_writes("rnd_w", 0); end
        1: begin cmd_l(8'($urandom), 8'($urandom_range(1, 6)), gap); compare_writes("rnd_l", 0); end
        2: cmd_r(8'($urandom), $urandom_range(0, 4), gap);
        3: begin send(8'h48); exp_cpu = 1'b1; check("rnd_h", cpu_reset, exp_cpu); end
        4: begin send(8'h47); exp_cpu = 1'b0; check("rnd_g", cpu_reset, exp_cpu); end
        default: begin
          do b = 8'($urandom);
          while (b == 8'h47 || b == 8'h48 || b == 8'h4C || b == 8'h52 || b == 8'h57);
          send(b);
          compare_writes("rnd_junk", 0);
          check("rnd_junk_cpu", cpu_reset, exp_cpu);
        end
      endcase
    end

    send(8'h47);
    check("pre_rst_cpu", cpu_reset, 0);
    send(8'h4C); send(8'h20); send(8'h05);
    send(8'hA1); exp_wr(8'h20, 8'hA1);
    send(8'hA2); exp_wr(8'h21, 8'hA2);
    reset = 1'b1; idle(1); reset = 1'b0;
    send(8'h01); send(8'h02); send(8'h03);
    compare_writes("rst_mid_l", 0);
    check("rst_mid_cpu", cpu_reset, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snoop_loader.md
# snoop_loader

Byte-stream command interpreter that sits directly upstream of `discus`'s snoop port. It turns host bytes, typically from a UART receiver, into snoop writes (`snoopa`/`snoopd`/`snoopp`), snoop reads (`snoopq` returned as a tx byte), and control of the core's `reset`. It lets a host halt the core, load program memory, release the core, and dump memory, with no testbench driving the port.

## Interface
Parameters:
- `READ_LAT`, 2: cycles from `snoopa` valid to `snoopq` valid at `discus`.
- `TIMEOUT`, 1000000: idle cycles mid-command before the command is aborted.

Ports:
- `clk` in 1: single clock; also drives `discus` `snoop_clk`.
- `reset` in 1: synchronous, active-high; clears all state.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is consumed the same cycle.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response pending; held until `tx_ready`.
- `tx_ready` in 1: downstream accepts `tx_data` when high with `tx_valid`.
- `busy` out 1: high in RD_WAIT and TX; rx bytes are discarded while high.
- `cpu_reset` out 1: to `discus` `reset`; high = core halted.
- `snoopa` out 8: snoop address.
- `snoopd` out 8: snoop write data.
- `snoopp` out 1: snoop write strobe; one cycle per byte written.
- `snoopq` in 8: snoop read data from `discus`.

## Operation
- All outputs are registered.
- Reset values: `cpu_reset`=1, `snoopa`=0, `snoopd`=0, `snoopp`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, state=IDLE.
- Commands (first byte) in IDLE:
  - 0x48 'H': `cpu_reset`<=1.
  - 0x47 'G': `cpu_reset`<=0.
  - 0x57 'W' addr data: writes one byte.
  - 0x4C 'L' addr count data×N: block write. N=count, with count 0 meaning 256.
  - 0x52 'R' addr: reads one byte and returns it on tx.
  - Any other byte is ignored; state stays IDLE.
- States: IDLE, W_ADDR, W_DATA, L_ADDR, L_CNT, L_DATA, R_ADDR, RD_WAIT, TX.
- Write: on the data byte, `snoopa`<=addr, `snoopd`<=data, `snoopp`<=1 for exactly one cycle. Return to IDLE, or stay in L_DATA if bytes remain.
- Block load:
  - addr is latched in L_ADDR and count in L_CNT.
  - Each data byte pulses `snoopp` at the current addr.
  - addr then increments mod 256, so 0xFF wraps to 0x00.
  - After the final byte, return to IDLE.
- Writes are performed whether or not `cpu_reset` is high. The host is responsible for halting first.
- Read:
  - In R_ADDR, `snoopa`<=addr, then go to RD_WAIT.
  - Count READ_LAT cycles, then `tx_data`<=`snoopq`, `tx_valid`<=1, go to TX.
  - In TX, the byte is accepted on the cycle with `tx_valid`&&`tx_ready`. `tx_valid`<=0 next cycle and state returns to IDLE.
- Timeout:
  - In W_ADDR, W_DATA, L_ADDR, L_CNT, L_DATA and R_ADDR, a counter increments every cycle without `rx_valid` and clears on `rx_valid`.
  - Reaching TIMEOUT returns the block to IDLE with no write.
  - Block-load bytes already written stay written.
  - The timeout does not apply in RD_WAIT or TX.
- `reset` mid-command aborts immediately. No partial `snoopp` pulse occurs after reset, and `cpu_reset` returns to 1.

## Timing
- Byte consumed in cycle n → state/register update visible at n+1.
- Write data byte at cycle n → `snoopa`/`snoopd`/`snoopp`=1 at n+1, `snoopp`=0 at n+2 unless a new data byte arrived at n+1.
- Back-to-back L data bytes on consecutive cycles give consecutive `snoopp` pulses at consecutive addresses, for full throughput.
- 'H'/'G' at cycle n → `cpu_reset` changes at n+1.
- R addr byte at cycle n → `snoopa` valid at n+1 → `snoopq` sampled at n+1+READ_LAT → `tx_valid` at n+2+READ_LAT.
- `snoopa` holds its last value when idle. `snoopd` holds its last value.

## Test plan
- After reset, check `cpu_reset`=1, `snoopp`=0, `tx_valid`=0. Send 'G' → `cpu_reset`=0 next cycle. Send 'H' → `cpu_reset`=1.
- Send 'W',0x03,0xE0 → a single cycle with `snoopa`=0x03, `snoopd`=0xE0, `snoopp`=1. Then 'R',0x03 against a `discus` model → `tx_data`=0xE0.
- Send 'L',0xFE,0x03,0x11,0x22,0x33 on consecutive cycles → `snoopp` pulses at 0xFE, 0xFF, 0x00 with 0x11, 0x22, 0x33 (wrap check).
- Send 'L',0x00,0x00 followed by 256 bytes → exactly 256 `snoopp` pulses, last at 0xFF. Then IDLE.
- Send 'W',0x10, then idle TIMEOUT cycles, then 0x55 → no `snoopp`. 0x55 is treated as an unknown command.
- Send 'R',0x05 with `tx_ready`=0 for 10 cycles, sending 'G' during TX → `tx_valid` held, `busy`=1, 'G' discarded (`cpu_reset` unchanged). Raise `tx_ready` → one transfer, then IDLE. Assert `reset` mid-'L' → no further pulses, `cpu_reset`=1.
